custom_power_unit: RTL and testbench

Parametrised exponentiation engine for the Custom Logic Block slot behind the AMBA bus interface logic, at `BASE_ADDR` inside the 128 kB custom window. It generalises the fixed single-cycle cube to a software-selectable exponent, a configurable operand width and a full double-width result. It computes by iterative multiplication and stalls bus accesses through `ack` while busy. Offset 0x00 keeps cube semantics after reset: write an operand, then read the result.

---
 rtl/custom_power_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_custom_power_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/custom_power_unit.sv
// -----------------------------------------------------------------------------
// custom_power_unit
//
// Bus-mapped exponentiation engine. Software writes an operand to offset 0x00
// and the unit computes operand^EXP mod 2^(2*WIDTH) by repeated
// multiplication, one multiply per clock. Accesses that depend on the
// running computation (0x00 write, 0x00/0x08 read) are stalled through `ack`
// until the unit is idle again. After reset EXP=3, so offset 0x00 behaves
// as a cube unit.
//
// Register map (word offsets inside the 32-byte block at BASE_ADDR):
//   0x00  W: start with operand data_in[WIDTH-1:0]   R: result[31:0]
//   0x04  RW: exponent [EXP_BITS-1:0], reset 3
//   0x08  R: result[63:32] (zero-extended when 2*WIDTH < 64)
//   0x0C  R: {ovf, done, busy}   W: write-1-to-clear done (bit1), ovf (bit2)
//   0x10-0x1C  read 0, writes ignored
//
// Parameters:
//   WIDTH      operand width, 1..32; result is 2*WIDTH bits
//   EXP_BITS   exponent register width
//   BASE_ADDR  byte address of offset 0x00, 32-byte aligned
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   strobe    bus access pending; adr/we/data_in stable until ack
//   we        1 = write, 0 = read
//   adr       byte address
//   data_in   write data
//   ack       access completes this cycle
//   data_out  read data (combinational mux on the word offset)
//
// Build option:
//   CUSTOM_POWER_OVF_EN  when defined, STATUS.ovf is sticky-set whenever a
//                        multiply discards non-zero upper product bits.
//                        When undefined no overflow logic exists and
//                        STATUS bit2 always reads 0.
// -----------------------------------------------------------------------------
module custom_power_unit #(
  parameter int          WIDTH     = 32,
  parameter int          EXP_BITS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'hA016_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strobe,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] data_in,
  output logic        ack,
  output logic [31:0] data_out
);

  localparam int RW = 2 * WIDTH;   // result / accumulator width
  localparam int PW = 3 * WIDTH;   // full acc*op product width

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OFF_OPERAND = 3'd0;
  localparam logic [2:0] OFF_EXP     = 3'd1;
  localparam logic [2:0] OFF_RES_HI  = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;

  state_t               r_state;
  state_t               w_state_next;
  logic [RW-1:0]        r_acc;
  logic [RW-1:0]        r_result;
  logic [WIDTH-1:0]     r_op;
  logic [EXP_BITS-1:0]  r_cnt;
  logic [EXP_BITS-1:0]  r_exp;
  logic                 r_done;
  logic                 w_ovf;
  logic [RW-1:0]        w_acc_next;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       w_match;
  logic [2:0] w_off;
  logic       w_sel;
  logic       w_busy;
  logic       w_stall;
  logic       w_start;
  logic       w_step;
  logic       w_finish;
  logic       w_exp_wr;
  logic       w_status_wr;

  assign w_match = (adr[31:5] == BASE_ADDR[31:5]);
  assign w_off   = adr[4:2];
  assign w_sel   = strobe && w_match;

  // Byte-lane bits of the address and write-data bits above the operand
  // width carry no meaning for this block.
  logic w_unused;
  assign w_unused = &{1'b0, adr[1:0], data_in};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred when a branch leaves the signal untouched.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)      w_state_next = S_RUN;
      S_RUN:   if (r_cnt == '0)  w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy      = (r_state == S_RUN);
    // Only accesses that touch the operand/result wait for the engine.
    w_stall     = w_sel && w_busy &&
                  (( we && (w_off == OFF_OPERAND)) ||
                   (!we && ((w_off == OFF_OPERAND) || (w_off == OFF_RES_HI))));
    ack         = strobe && !w_stall;
    // A stalled 0x00 write falls through here on the first IDLE cycle, so
    // back-to-back operations restart without a bubble.
    w_start     = w_sel && we && (w_off == OFF_OPERAND) && !w_busy;
    w_step      = w_busy && (r_cnt != '0);
    w_finish    = w_busy && (r_cnt == '0);
    w_exp_wr    = w_sel && we && (w_off == OFF_EXP);
    w_status_wr = w_sel && we && (w_off == OFF_STATUS);
  end

  // ---------------------------------------------------------------------------
  // Multiplier and optional overflow tracking
  // ---------------------------------------------------------------------------
`ifdef CUSTOM_POWER_OVF_EN
  logic [PW-1:0] w_prod;
  logic          r_ovf;

  assign w_prod     = PW'(r_acc) * PW'(r_op);
  assign w_acc_next = w_prod[RW-1:0];

  // Sticky until the next start or a W1C; a set on the same edge as a W1C
  // wins so the flag is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_ovf <= 1'b0;
    end else if (w_step && (|w_prod[PW-1:RW])) begin
      r_ovf <= 1'b1;
    end else if (w_status_wr && data_in[2]) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_ovf = r_ovf;
`else
  // Truncating multiply: only the low 2*WIDTH bits are ever needed.
  assign w_acc_next = r_acc * RW'(r_op);
  assign w_ovf      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath and software-visible registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_exp    <= EXP_BITS'(3);
    end else begin
      if (w_start) begin
        r_acc <= RW'(1);
        r_cnt <= r_exp;
        r_op  <= data_in[WIDTH-1:0];
      end else if (w_step) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_finish) begin
        r_result <= r_acc;
      end

      // Completion beats a simultaneous W1C.
      if (w_start) begin
        r_done <= 1'b0;
      end else if (w_finish) begin
        r_done <= 1'b1;
      end else if (w_status_wr && data_in[1]) begin
        r_done <= 1'b0;
      end

      // Exponent is sampled at start, so a write while busy only affects
      // the next operation.
      if (w_exp_wr) begin
        r_exp <= data_in[EXP_BITS-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [63:0] w_result64;
  assign w_result64 = 64'(r_result);

  always_comb begin
    data_out = '0;
    if (w_match) begin
      case (w_off)
        OFF_OPERAND: data_out = w_result64[31:0];
        OFF_EXP:     data_out = 32'(r_exp);
        OFF_RES_HI:  data_out = w_result64[63:32];
        OFF_STATUS:  data_out = {29'd0, w_ovf, r_done, w_busy};
        default:     data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_power_unit.sv
// -----------------------------------------------------------------------------
// tb_custom_power_unit
//
// Directed bench for custom_power_unit. Two instances share clock, reset and
// bus lines: the default 32-bit unit and a WIDTH=8 unit; `sel8` steers the
// strobe to one of them. The stimulus task pushes the expected read data
// into a scoreboard queue and checks the stall length itself; a separate
// monitor pops and compares whenever the selected unit acks.
// -----------------------------------------------------------------------------
module tb_custom_power_unit;

  localparam logic [31:0] B = 32'hA016_0000;

`ifdef CUSTOM_POWER_OVF_EN
  localparam logic [31:0] OVF_STATUS = 32'h6;
`else
  localparam logic [31:0] OVF_STATUS = 32'h2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic        we = 1'b0;
  logic        sel8 = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] data_in = '0;

  logic        strobe32, strobe8;
  logic        ack32, ack8;
  logic [31:0] dout32, dout8;
  logic        w_ack;
  logic [31:0] w_rdata;

  assign strobe32 = strobe && !sel8;
  assign strobe8  = strobe &&  sel8;
  assign w_ack    = sel8 ? ack8  : ack32;
  assign w_rdata  = sel8 ? dout8 : dout32;

  custom_power_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe   (strobe32),
    .we       (we),
    .adr      (adr),
    .data_in  (data_in),
    .ack      (ack32),
    .data_out (dout32)
  );

  custom_power_unit #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe   (strobe8),
    .we       (we),
    .adr      (adr),
    .data_in  (data_in),
    .ack      (ack8),
    .data_out (dout8)
  );

  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (strobe && w_ack) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_rd) check(mon_e.name, w_rdata, mon_e.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus access: exp_wait < 0 skips the stall-length comparison.
  // ---------------------------------------------------------------------------
  task automatic bus(input logic s8, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input int exp_wait, input string nm);
    int   waits;
    logic got;
    sb_q.push_back('{is_rd: !w, data: exp_rd, name: nm});
    sel8    = s8;
    we      = w;
    adr     = a;
    data_in = wd;
    strobe  = 1'b1;
    waits   = 0;
    got     = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (w_ack) got = 1'b1;
      else       waits++;
    end
    if (!got) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_back());
    end else if (exp_wait >= 0) begin
      check({nm, "_wait"}, 32'(waits), 32'(exp_wait));
    end
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int ew, input string nm);
    bus(1'b0, 1'b1, a, d, 32'd0, ew, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input int ew, input string nm);
    bus(1'b0, 1'b0, a, 32'd0, e, ew, nm);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values, no stall when idle
    rd(B + 32'h04, 32'd3, 0, "rst_exp");
    rd(B + 32'h00, 32'd0, 0, "rst_lo");
    rd(B + 32'h08, 32'd0, 0, "rst_hi");
    rd(B + 32'h0C, 32'd0, 0, "rst_status");
    rd(B + 32'h10, 32'd0, 0, "reserved_rd");
    rd(B + 32'h20, 32'd0, 0, "nomatch_rd");

    // Default cube with a stalled read
    wr(B + 32'h00, 32'd5, 0, "cube_start");
    rd(B + 32'h00, 32'd125, 4, "cube_lo");
    rd(B + 32'h08, 32'd0, 0, "cube_hi");
    rd(B + 32'h0C, 32'h2, 0, "cube_status");

    // Exponent 0: busy for exactly one cycle, result 1
    wr(B + 32'h04, 32'd0, 0, "exp0_wr");
    rd(B + 32'h04, 32'd0, 0, "exp0_rd");
    wr(B + 32'h00, 32'hFFFF_FFFF, 0, "exp0_start");
    rd(B + 32'h0C, 32'h1, 0, "exp0_busy");
    rd(B + 32'h0C, 32'h2, 0, "exp0_done");
    rd(B + 32'h00, 32'd1, 0, "exp0_lo");
    rd(B + 32'h08, 32'd0, 0, "exp0_hi");

    // Large result, then overflow
    wr(B + 32'h04, 32'd3, 0, "big_exp");
    wr(B + 32'h00, 32'h0010_0000, 0, "big_start");
    rd(B + 32'h00, 32'd0, 4, "big_lo");
    rd(B + 32'h08, 32'h1000_0000, 0, "big_hi");
    rd(B + 32'h0C, 32'h2, 0, "big_status");
    wr(B + 32'h00, 32'h0040_0000, 0, "ovf_start");
    rd(B + 32'h00, 32'd0, 4, "ovf_lo");
    rd(B + 32'h08, 32'd0, 0, "ovf_hi");
    rd(B + 32'h0C, OVF_STATUS, 0, "ovf_status");
    wr(B + 32'h0C, 32'h6, 0, "w1c");
    rd(B + 32'h0C, 32'h0, 0, "w1c_status");

    // Writes outside the block must not start an operation
    wr(B + 32'h20, 32'd7, 0, "nomatch_wr");
    rd(B + 32'h0C, 32'h0, 0, "nomatch_status");

    // Back-to-back starts with EXP=15
    wr(B + 32'h04, 32'd15, 0, "b2b_exp");
    wr(B + 32'h00, 32'd2, 0, "b2b_first");
    wr(B + 32'h00, 32'd3, 16, "b2b_second");
    rd(B + 32'h00, 32'd14348907, 16, "b2b_lo");
    rd(B + 32'h08, 32'd0, 0, "b2b_hi");
    rd(B + 32'h0C, 32'h2, 0, "b2b_status");

    // Asynchronous reset in the middle of a run
    wr(B + 32'h00, 32'd2, 0, "rstrun_start");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    rd(B + 32'h0C, 32'h0, 0, "rstrun_status");
    rd(B + 32'h04, 32'd3, 0, "rstrun_exp");
    rd(B + 32'h00, 32'd0, 0, "rstrun_lo");
    rst_n = 1'b1;
    rd(B + 32'h08, 32'd0, 0, "postrst_hi");
    rd(B + 32'h0C, 32'h0, 0, "postrst_status");
    rd(B + 32'h04, 32'd3, 0, "postrst_exp");

    // Reduced width instance: 0xFF^2 = 0xFE01, upper write bits ignored
    bus(1'b1, 1'b1, B + 32'h04, 32'd2, 32'd0, 0, "w8_exp");
    bus(1'b1, 1'b1, B + 32'h00, 32'h1234_56FF, 32'd0, 0, "w8_start");
    bus(1'b1, 1'b0, B + 32'h00, 32'd0, 32'h0000_FE01, 3, "w8_lo");
    bus(1'b1, 1'b0, B + 32'h08, 32'd0, 32'd0, 0, "w8_hi");
    bus(1'b1, 1'b0, B + 32'h0C, 32'd0, 32'h2, 0, "w8_status");

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
